dmem_resp: RTL and testbench

- Data-memory responder for the single-cycle RV32 core's load/store port. It sits between the core's data interface (addr, wdata, memop, memwr) and a synchronous single-port block RAM.
- Handles byte, halfword and word loads and stores, including little-endian lane steering and sign/zero extension.
- Misaligned accesses are split into two RAM transactions.
- Runs as a small FSM with a valid/ready request side and a pulsed response side.

---
 rtl/dmem_pkg.sv | 35 +++
 rtl/dmem_resp_if.sv | 17 +
 rtl/dmem_load_fmt.sv | 28 ++
 rtl/dmem_resp.sv | 153 +++++++++++++++
 tb/tb_dmem_resp.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared types and decode helpers for the data-memory responder.
// Memop encodings, access-size decode and FSM state encoding.
package dmem_pkg;

  localparam logic [2:0] MEMOP_LB  = 3'b000;
  localparam logic [2:0] MEMOP_LH  = 3'b001;
  localparam logic [2:0] MEMOP_LW  = 3'b010;
  localparam logic [2:0] MEMOP_LBU = 3'b100;
  localparam logic [2:0] MEMOP_LHU = 3'b101;

  typedef enum logic [1:0] {IDLE, RD0, RD1, WR1} state_t;

  // Access size in bytes from memop[1:0]; 2'b11 behaves as a word.
  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    case (sz)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [3:0] lane_mask(input logic [1:0] sz);
    case (sz)
      2'b00:   return 4'b0001;
      2'b01:   return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // True when the access runs past the end of its word.
  function automatic logic is_split(input logic [1:0] o, input logic [1:0] sz);
    return ({2'b00, o} + {1'b0, size_bytes(sz)}) > 4'd4;
  endfunction

endpackage

// File: rtl/dmem_resp_if.sv
// Core-side load/store port: valid/ready request, pulsed response.
interface dmem_resp_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [2:0]  memop;
  logic        memwr;
  logic        resp_valid;
  logic [31:0] rdata;
  logic        resp_err;

  modport master (output req_valid, addr, wdata, memop, memwr,
                  input  req_ready, resp_valid, rdata, resp_err);
  modport slave  (input  req_valid, addr, wdata, memop, memwr,
                  output req_ready, resp_valid, rdata, resp_err);
endinterface

// File: rtl/dmem_load_fmt.sv
// Load formatter: picks the addressed bytes out of a {hi, lo} word pair
// and sign/zero extends them according to memop.
module dmem_load_fmt
  import dmem_pkg::*;
(
  input  logic [31:0] lo,
  input  logic [31:0] hi,
  input  logic [1:0]  o,
  input  logic [2:0]  memop,
  output logic [31:0] data
);

  logic [31:0] w;

  assign w = 32'({hi, lo} >> {o, 3'b000});

  always_comb begin
    data = w;
    case (memop)
      MEMOP_LB:  data = {{24{w[7]}}, w[7:0]};
      MEMOP_LH:  data = {{16{w[15]}}, w[15:0]};
      MEMOP_LBU: data = {24'h0, w[7:0]};
      MEMOP_LHU: data = {16'h0, w[15:0]};
      default:   data = w;
    endcase
  end

endmodule

// File: rtl/dmem_resp.sv
// Data-memory responder between the core load/store port and a 1-cycle BRAM.
// DMEM_SPLIT_EN: split accesses crossing a word; otherwise reject them with resp_err.
module dmem_resp
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              rst,
  dmem_resp_if.slave        bus,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [3:0]        ram_we,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  state_t             state, state_d;
  logic [ADDR_W-1:0]  word_q, word_nx;
  logic [1:0]         o_q;
  logic [2:0]         memop_q;
  logic [31:0]        rdata_q, fmt_lo, fmt_data;
  logic               resp_valid_q, resp_err_q;
  logic               resp_valid_d, resp_err_d, load_done;
  logic               accept, split_in;
  logic [3:0]         we_raw;
`ifdef DMEM_SPLIT_EN
  logic [31:0]        wdata_q, word0_q;
`endif

  assign accept   = bus.req_valid && (state == IDLE);
  assign split_in = is_split(bus.addr[1:0], bus.memop[1:0]);
  assign word_nx  = word_q + ADDR_W'(1);

  assign bus.req_ready  = (state == IDLE);
  assign bus.resp_valid = resp_valid_q;
  assign bus.rdata      = rdata_q;
  assign bus.resp_err   = resp_err_q;

  // Write enables are forced off whenever reset is held.
  assign ram_we = rst ? 4'b0000 : we_raw;

  always_comb begin
    state_d      = state;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    load_done    = 1'b0;
    ram_addr     = word_q;
    we_raw       = 4'b0000;
    ram_wdata    = bus.wdata << {bus.addr[1:0], 3'b000};
    case (state)
      IDLE: begin
        ram_addr = bus.addr[ADDR_W+1:2];
        if (accept) begin
`ifdef DMEM_SPLIT_EN
          if (bus.memwr) begin
            we_raw = 4'({4'b0000, lane_mask(bus.memop[1:0])} << bus.addr[1:0]);
            if (split_in) state_d = WR1;
            else          resp_valid_d = 1'b1;
          end else begin
            state_d = RD0;
          end
`else
          if (split_in) begin
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else if (bus.memwr) begin
            we_raw       = 4'({4'b0000, lane_mask(bus.memop[1:0])} << bus.addr[1:0]);
            resp_valid_d = 1'b1;
          end else begin
            state_d = RD0;
          end
`endif
        end
      end
      RD0: begin
`ifdef DMEM_SPLIT_EN
        if (is_split(o_q, memop_q[1:0])) begin
          ram_addr = word_nx;
          state_d  = RD1;
        end else begin
          load_done    = 1'b1;
          resp_valid_d = 1'b1;
          state_d      = IDLE;
        end
`else
        load_done    = 1'b1;
        resp_valid_d = 1'b1;
        state_d      = IDLE;
`endif
      end
`ifdef DMEM_SPLIT_EN
      RD1: begin
        ram_addr     = word_nx;
        load_done    = 1'b1;
        resp_valid_d = 1'b1;
        state_d      = IDLE;
      end
      WR1: begin
        // Upper lanes of the shifted mask/data spill into the next word.
        ram_addr     = word_nx;
        we_raw       = 4'(({4'b0000, lane_mask(memop_q[1:0])} << o_q) >> 4);
        ram_wdata    = wdata_q >> {3'd4 - {1'b0, o_q}, 3'b000};
        resp_valid_d = 1'b1;
        state_d      = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

`ifdef DMEM_SPLIT_EN
  assign fmt_lo = (state == RD1) ? word0_q : ram_rdata;
`else
  assign fmt_lo = ram_rdata;
`endif

  dmem_load_fmt u_fmt (
    .lo    (fmt_lo),
    .hi    (ram_rdata),
    .o     (o_q),
    .memop (memop_q),
    .data  (fmt_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      rdata_q      <= '0;
    end else begin
      state        <= state_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      if (load_done) rdata_q <= fmt_data;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      word_q  <= bus.addr[ADDR_W+1:2];
      o_q     <= bus.addr[1:0];
      memop_q <= bus.memop;
`ifdef DMEM_SPLIT_EN
      wdata_q <= bus.wdata;
`endif
    end
`ifdef DMEM_SPLIT_EN
    if (state == RD0) word0_q <= ram_rdata;
`endif
  end

endmodule

// File: tb/tb_dmem_resp.sv
// Scoreboard bench for dmem_resp: byte-level reference memory, BRAM model,
// expected responses queued at accept and checked as resp_valid pulses.
module tb_dmem_resp;
  import dmem_pkg::*;

  localparam int ADDR_W = 15;
  localparam logic [31:0] AMASK = (32'h1 << (ADDR_W + 2)) - 1;
`ifdef DMEM_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [ADDR_W-1:0] ram_addr;
  logic [3:0]        ram_we;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;
  logic [31:0]       mem [0:(1<<ADDR_W)-1];

  dmem_resp_if bus();

  dmem_resp #(.ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (ram_we[i]) mem[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
    ram_rdata <= mem[ram_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;

  exp_t        q[$];
  exp_t        me;
  logic [7:0]  refm [int];
  logic [31:0] last_rd = 32'h0;
  int          n_chk = 0;
  int          n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic int szb(input logic [2:0] op);
    return (op[1:0] == 2'b00) ? 1 : (op[1:0] == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [7:0] rb(input logic [31:0] a);
    int k = int'(a & AMASK);
    return refm.exists(k) ? refm[k] : 8'h00;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [2:0] op);
    logic [31:0] v = 32'h0;
    for (int i = 0; i < szb(op); i++) v[8*i +: 8] = rb(a + i);
    case (op)
      MEMOP_LB: v = {{24{v[7]}}, v[7:0]};
      MEMOP_LH: v = {{16{v[15]}}, v[15:0]};
      default:  ;
    endcase
    return v;
  endfunction

  task automatic ref_store(input logic [31:0] a, input logic [31:0] wd, input int n);
    for (int i = 0; i < n; i++) refm[int'((a + i) & AMASK)] = wd[8*i +: 8];
  endtask

  // Scoreboard check on every response pulse.
  always @(negedge clk) begin
    if (!rst && bus.resp_valid) begin
      if (q.size() == 0) begin
        chk("spurious_resp", 32'd1, 32'd0);
      end else begin
        me = q.pop_front();
        chk("rdata", bus.rdata, me.rdata);
        chk("resp_err", {31'h0, bus.resp_err}, {31'h0, me.err});
        chk("latency", cyc - me.acc + 1, me.lat);
      end
    end
  end

  task automatic do_req(input logic [31:0] a, input logic [31:0] wd, input logic [2:0] op,
                        input logic wr, input logic chk_we, input logic [3:0] exp_we);
    exp_t e;
    int   n  = szb(op);
    bit   sp = (int'(a[1:0]) + n) > 4;
    bit   er = sp && !SPLIT;
    int   k  = 0;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.addr = a; bus.wdata = wd; bus.memop = op; bus.memwr = wr;
    while (!bus.req_ready && k < 20) begin @(negedge clk); k++; end
    if (k >= 20) chk("ready_wait", 32'd0, 32'd1);
    #1;
    if (chk_we) begin
      chk("ram_we", {28'h0, ram_we}, {28'h0, exp_we});
      chk("ram_addr", 32'(ram_addr), 32'(a[ADDR_W+1:2]));
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    e.acc = cyc;
    e.err = er;
    e.lat = er ? 1 : wr ? (sp ? 2 : 1) : (sp ? 3 : 2);
    if (!er) begin
      if (wr) ref_store(a, wd, n);
      else    last_rd = ref_load(a, op);
    end
    e.rdata = last_rd;
    q.push_back(e);
  endtask

  task automatic wait_drain();
    int k = 0;
    while (q.size() != 0 && k < 20) begin @(negedge clk); #1; k++; end
    if (q.size() != 0) begin
      chk("drain", q.size(), 32'd0);
      q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    logic [31:0] w3, w4;
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 32'h0;
    bus.req_valid = 1'b0; bus.addr = 32'h0; bus.wdata = 32'h0;
    bus.memop = MEMOP_LW; bus.memwr = 1'b0;

    // Reset state, with a store request held during reset.
    repeat (2) @(negedge clk);
    bus.req_valid = 1'b1; bus.memwr = 1'b1; bus.addr = 32'h40; bus.wdata = 32'h12345678;
    #1;
    chk("rst_ram_we", {28'h0, ram_we}, 32'h0);
    chk("rst_resp_valid", {31'h0, bus.resp_valid}, 32'h0);
    chk("rst_rdata", bus.rdata, 32'h0);
    chk("rst_resp_err", {31'h0, bus.resp_err}, 32'h0);
    chk("rst_ready", {31'h0, bus.req_ready}, 32'h1);
    @(negedge clk);
    bus.req_valid = 1'b0; bus.memwr = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mem_untouched", mem[16], 32'h0);

    // Aligned word, byte and halfword traffic.
    do_req(32'h10, 32'hDEADBEEF, MEMOP_LW, 1'b1, 1'b1, 4'b1111);
    do_req(32'h10, 32'h0,        MEMOP_LW, 1'b0, 1'b0, 4'b0000);
    wait_drain();
    chk("lw_value", last_rd, 32'hDEADBEEF);
    do_req(32'h13, 32'h000000A5, MEMOP_LB,  1'b1, 1'b1, 4'b1000);
    do_req(32'h13, 32'h0,        MEMOP_LB,  1'b0, 1'b0, 4'b0000);
    do_req(32'h13, 32'h0,        MEMOP_LBU, 1'b0, 1'b0, 4'b0000);
    do_req(32'h16, 32'h00008001, MEMOP_LH,  1'b1, 1'b1, 4'b1100);
    do_req(32'h16, 32'h0,        MEMOP_LH,  1'b0, 1'b0, 4'b0000);
    wait_drain();
    chk("lh_value", last_rd, 32'hFFFF8001);
    do_req(32'h16, 32'h0,        MEMOP_LHU, 1'b0, 1'b0, 4'b0000);
    do_req(32'h10, 32'h0,        3'b011,    1'b0, 1'b0, 4'b0000);
    // Store followed immediately by a load accepted during the store's response.
    do_req(32'h20, 32'hCAFEF00D, MEMOP_LW, 1'b1, 1'b1, 4'b1111);
    do_req(32'h20, 32'h0,        MEMOP_LW, 1'b0, 1'b0, 4'b0000);
    do_req(32'h21, 32'h0,        MEMOP_LB, 1'b0, 1'b0, 4'b0000);
    wait_drain();

    // Random aligned accesses over a small window.
    for (int it = 0; it < 24; it++) begin
      logic [1:0]  sz = 2'($urandom_range(0, 2));
      logic [31:0] a  = 32'($urandom_range(64, 79)) << 2;
      logic [2:0]  op;
      logic        wr = 1'($urandom_range(0, 1));
      if (sz == 2'd0)      a[1:0] = 2'($urandom_range(0, 3));
      else if (sz == 2'd1) a[1:0] = {1'($urandom_range(0, 1)), 1'b0};
      op = {(!wr && sz != 2'd2) ? 1'($urandom_range(0, 1)) : 1'b0, sz};
      do_req(a, $urandom, op, wr, 1'b0, 4'b0000);
    end
    wait_drain();

`ifdef DMEM_SPLIT_EN
    do_req(32'h0E, 32'h11223344, MEMOP_LW, 1'b1, 1'b1, 4'b1100);
    wait_drain();
    chk("split_w3_hi", {16'h0, mem[3][31:16]}, 32'h3344);
    chk("split_w4_lo", {16'h0, mem[4][15:0]},  32'h1122);
    do_req(32'h0E, 32'h0, MEMOP_LW, 1'b0, 1'b0, 4'b0000);
    wait_drain();
    chk("split_lw_value", last_rd, 32'h11223344);
    do_req(32'h1B, 32'h0000C0DE, MEMOP_LH,  1'b1, 1'b1, 4'b1000);
    do_req(32'h1B, 32'h0,        MEMOP_LH,  1'b0, 1'b0, 4'b0000);
    do_req(32'h1B, 32'h0,        MEMOP_LHU, 1'b0, 1'b0, 4'b0000);
    // Last word wraps to word 0.
    do_req(32'h1FFFE, 32'hA1B2C3D4, MEMOP_LW, 1'b1, 1'b1, 4'b1100);
    wait_drain();
    chk("wrap_last_hi", {16'h0, mem[(1<<ADDR_W)-1][31:16]}, 32'hC3D4);
    chk("wrap_w0_lo",   {16'h0, mem[0][15:0]},              32'hA1B2);
    do_req(32'h1FFFE, 32'h0, MEMOP_LW, 1'b0, 1'b0, 4'b0000);
    wait_drain();
`else
    w3 = mem[3]; w4 = mem[4];
    do_req(32'h03, 32'h0,        MEMOP_LH, 1'b0, 1'b1, 4'b0000);
    do_req(32'h0E, 32'h11223344, MEMOP_LW, 1'b1, 1'b1, 4'b0000);
    wait_drain();
    chk("err_w3_kept", mem[3], w3);
    chk("err_w4_kept", mem[4], w4);
    do_req(32'h10, 32'h0, MEMOP_LW, 1'b0, 1'b0, 4'b0000);
    wait_drain();
`endif

    // Reset while a load is waiting for RAM data.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.addr = 32'h10; bus.memop = MEMOP_LW; bus.memwr = 1'b0;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rd0_rst_resp", {31'h0, bus.resp_valid}, 32'h0);
    chk("rd0_rst_ready", {31'h0, bus.req_ready}, 32'h1);
    chk("rd0_rst_rdata", bus.rdata, 32'h0);
    rst = 1'b0; last_rd = 32'h0;
    repeat (3) @(negedge clk);

`ifdef DMEM_SPLIT_EN
    // Reset in the second half of a split store.
    bus.req_valid = 1'b1; bus.addr = 32'h2A; bus.wdata = 32'h55667788;
    bus.memop = MEMOP_LW; bus.memwr = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    ref_store(32'h2A, 32'h55667788, 2);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("wr1_rst_we", {28'h0, ram_we}, 32'h0);
    @(negedge clk);
    chk("wr1_rst_resp", {31'h0, bus.resp_valid}, 32'h0);
    chk("wr1_rst_ready", {31'h0, bus.req_ready}, 32'h1);
    chk("wr1_no_second_half", mem[11], 32'h0);
    chk("wr1_first_half", {16'h0, mem[10][31:16]}, 32'h7788);
    rst = 1'b0;
    @(negedge clk);
    // Reset in the second read cycle of a split load.
    bus.req_valid = 1'b1; bus.addr = 32'h0E; bus.memop = MEMOP_LW; bus.memwr = 1'b0;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rd1_rst_resp", {31'h0, bus.resp_valid}, 32'h0);
    chk("rd1_rst_ready", {31'h0, bus.req_ready}, 32'h1);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("rd1_rst_quiet", {31'h0, bus.resp_valid}, 32'h0);
    end
    do_req(32'h28, 32'h0, MEMOP_LW, 1'b0, 1'b0, 4'b0000);
`endif

    do_req(32'h20, 32'h0, MEMOP_LW, 1'b0, 1'b0, 4'b0000);
    wait_drain();
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
